shift_sequencer: RTL and testbench
==================================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the data width of the controlled shift register.
REQ-002 The block SHALL have parameter CNT_W, default 3, the width of the shift count.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port cmd_valid  input  1  a command is presented.
REQ-006 The block SHALL have port cmd_ready  output  1  the sequencer can accept a command.
REQ-007 The block SHALL have port cmd_data  input  WIDTH  the parallel load value.
REQ-008 The block SHALL have port cmd_dir  input  1  shift direction: 0 = right, 1 = left.
REQ-009 The block SHALL have port cmd_count  input  CNT_W  the number of shifts, 0 to 2^CNT_W-1.
REQ-010 The block SHALL have port usr_sel  output  2  the shift register mode: 00 hold, 01 shift right, 10 shift left, 11 load.
REQ-011 The block SHALL have port usr_data  output  WIDTH  the parallel data to the shift register.
REQ-012 The block SHALL have port usr_q  input  WIDTH  the shift register output.
REQ-013 The block SHALL have port result  output  WIDTH  the captured final register value.
REQ-014 The block SHALL have port done  output  1  a one-cycle completion pulse.
REQ-015 The block SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, SHIFT and FINISH.
REQ-017 In IDLE: cmd_ready=1 and usr_sel=00.
  - On cmd_valid&&cmd_ready, the block SHALL capture cmd_data, cmd_dir and cmd_count.
  - The FSM SHALL then go to LOAD.
REQ-018 In LOAD, for exactly one cycle: usr_sel=11 and usr_data=captured data.
  - If count==0, next state SHALL be FINISH.
  - Otherwise, next state SHALL be SHIFT.
REQ-019 In SHIFT: usr_sel=10 if dir=1, else 01.
  - The block SHALL hold SHIFT for exactly count cycles.
  - A remaining-shift counter SHALL decrement each cycle.
  - The FSM SHALL go to FINISH when the counter reaches its last shift.
REQ-020 In FINISH, for one cycle: usr_sel=00.
  - On the exit edge, result SHALL be loaded from usr_q.
  - On the same edge, done SHALL be set.
  - The FSM SHALL return to IDLE.
REQ-021 done SHALL be registered and high for exactly one cycle, coincident with the new result; cmd_ready is also 1 in that cycle.
REQ-022 Latency: for a command accepted at edge N, done SHALL be high in cycle N+3+count.
REQ-023 A command presented in the done cycle SHALL be accepted, giving back-to-back operation with no extra idle cycle.
REQ-024 usr_data SHALL be 0 in all states except LOAD.
REQ-025 result SHALL hold its value between completions.
REQ-026 cmd_* inputs SHALL be ignored while busy=1; there is no buffering.
REQ-027 The count arithmetic SHALL be unsigned CNT_W bits and SHALL never wrap below 0.
REQ-028 Unreachable state encodings SHALL go to IDLE.

Reset
REQ-029 On resetn=0, asynchronously:
  - state = IDLE
  - usr_sel = 00, usr_data = 0
  - result = 0, done = 0, busy = 0
  - cmd_ready = 1 after release
  - counter and captured fields = 0
REQ-030 Reset asserted mid-operation SHALL discard the command with no done pulse.
REQ-031 Operation SHALL resume on the first edge after resetn returns high.

Configuration
REQ-032 The macro SHIFT_SEQUENCER_ABORT_EN SHALL control an abort feature.
  - When defined: there SHALL be an input port abort (1 bit, active high).
  - abort=1 in LOAD, SHIFT or FINISH SHALL force the next state to IDLE, with usr_sel=00 from the next cycle, no done pulse and result unchanged.
  - abort in IDLE SHALL be ignored, and a simultaneous cmd_valid SHALL still be accepted.
  - When not defined: the abort port SHALL NOT exist, and every accepted command SHALL run to completion.

Verification
REQ-033 The bench SHALL instantiate a 4-bit shift register model with zero fill and WIDTH=4. It SHALL cover these scenarios:
  - Load and shift left: cmd_data=1010, dir=1, count=2 -> usr_sel sequence 11,10,10,00; done in cycle N+5; result=1000.
  - Load and shift right: cmd_data=1010, dir=0, count=1 -> usr_sel 11,01,00; result=0101; done in cycle N+4.
  - Zero count: cmd_data=0110, count=0 -> usr_sel 11,00; result=0110; done in cycle N+3.
  - Back-to-back: cmd_valid held high with two commands (1010/left/1 then 0011/right/2) -> second command accepted in the first done cycle; results 0100, then 0000.
  - Reset mid-operation: resetn=0 during SHIFT -> immediate IDLE outputs, no done pulse, result=0.
  - Abort (with SHIFT_SEQUENCER_ABORT_EN): abort=1 in the 2nd SHIFT cycle of count=3 -> IDLE next cycle, usr_sel=00, no done, result keeps its prior value.

Source files
------------

// File: rtl/shift_sequencer.sv
// Sequencer that drives a universal shift register through one load and N shifts.
// Define SHIFT_SEQUENCER_ABORT_EN to add the abort input.
module shift_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_count,
   output logic [1:0]       usr_sel,
   output logic [WIDTH-1:0] usr_data,
   input  logic [WIDTH-1:0] usr_q,
   output logic [WIDTH-1:0] result,
   output logic             done,
   output logic             busy
`ifdef SHIFT_SEQUENCER_ABORT_EN
   ,
   input  logic             abort
`endif
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FINISH} state_t;

   state_t           state;
   logic             dir_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] remain;
   logic             abort_i;

`ifdef SHIFT_SEQUENCER_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         usr_sel   <= 2'b00;
         usr_data  <= '0;
         result    <= '0;
         done      <= 1'b0;
         busy      <= 1'b0;
         cmd_ready <= 1'b1;
         dir_q     <= 1'b0;
         count_q   <= '0;
         remain    <= '0;
      end else begin
         done <= 1'b0;
         // Abort and illegal states share one exit path; result is left untouched.
         if ((abort_i && state != IDLE) || state > FINISH) begin
            state     <= IDLE;
            usr_sel   <= 2'b00;
            usr_data  <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            remain    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (cmd_valid && cmd_ready) begin
                     state     <= LOAD;
                     usr_sel   <= 2'b11;
                     usr_data  <= cmd_data;
                     dir_q     <= cmd_dir;
                     count_q   <= cmd_count;
                     busy      <= 1'b1;
                     cmd_ready <= 1'b0;
                  end
               end
               LOAD: begin
                  usr_data <= '0;
                  if (count_q == '0) begin
                     state   <= FINISH;
                     usr_sel <= 2'b00;
                  end else begin
                     state   <= SHIFT;
                     usr_sel <= dir_q ? 2'b10 : 2'b01;
                     remain  <= count_q;
                  end
               end
               SHIFT: begin
                  // remain is at least 1 on entry, so it never wraps.
                  if (remain <= CNT_W'(1)) begin
                     state   <= FINISH;
                     usr_sel <= 2'b00;
                     remain  <= '0;
                  end else begin
                     remain <= remain - 1'b1;
                  end
               end
               FINISH: begin
                  state     <= IDLE;
                  usr_sel   <= 2'b00;
                  result    <= usr_q;
                  done      <= 1'b1;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a 4-bit zero-fill shift register plant plus a
// command-level reference model; abort scenario only with SHIFT_SEQUENCER_ABORT_EN.
module tb_shift_sequencer;

   logic       clk = 1'b0;
   logic       resetn;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_data;
   logic       cmd_dir;
   logic [2:0] cmd_count;
   logic [1:0] usr_sel;
   logic [3:0] usr_data;
   logic [3:0] usr_q;
   logic [3:0] result;
   logic       done;
   logic       busy;
   logic       abort;
   logic       abort_accept;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [3:0]  last_result;

   always #5 clk = ~clk;

   shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .cmd_dir   (cmd_dir),
      .cmd_count (cmd_count),
      .usr_sel   (usr_sel),
      .usr_data  (usr_data),
      .usr_q     (usr_q),
      .result    (result),
      .done      (done),
      .busy      (busy)
`ifdef SHIFT_SEQUENCER_ABORT_EN
      ,
      .abort     (abort)
`endif
   );

   // Controlled plant: 00 hold, 01 right, 10 left, 11 load, zero fill.
   logic [3:0] sr;
   always @(posedge clk or negedge resetn) begin
      if (!resetn) sr <= 4'b0000;
      else begin
         case (usr_sel)
            2'b01:   sr <= sr >> 1;
            2'b10:   sr <= sr << 1;
            2'b11:   sr <= usr_data;
            default: sr <= sr;
         endcase
      end
   end
   assign usr_q = sr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic scramble_cmd();
      cmd_valid = 1'($urandom);
      cmd_data  = 4'($urandom);
      cmd_dir   = 1'($urandom);
      cmd_count = 3'($urandom);
   endtask

   // Idle cycles: outputs quiet, result held.
   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         chk("idle_done", done, 0);
         chk("idle_busy", busy, 0);
         chk("idle_ready", cmd_ready, 1);
         chk("idle_sel", usr_sel, 0);
         chk("idle_data", usr_data, 0);
         chk("idle_result", result, last_result);
         scramble_cmd();
         cmd_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   // Called at a negedge with the DUT in IDLE; returns at the negedge of the done cycle.
   task automatic run_cmd(input logic [3:0] d, input logic dir, input logic [2:0] cnt);
      logic [3:0]  exp_res;
      logic [1:0]  exp_sel;
      int unsigned n;
      exp_res = dir ? 4'(d << cnt) : 4'(d >> cnt);
      n = int'(cnt) + 2;
      chk("accept_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_data  = d;
      cmd_dir   = dir;
      cmd_count = cnt;
      abort     = abort_accept;
      @(negedge clk);
      abort = 1'b0;
      for (int unsigned k = 0; k < n; k++) begin
         if (k == 0) exp_sel = 2'b11;
         else if (k <= cnt) exp_sel = dir ? 2'b10 : 2'b01;
         else exp_sel = 2'b00;
         chk("run_sel", usr_sel, exp_sel);
         chk("run_data", usr_data, (k == 0) ? d : 4'b0000);
         chk("run_busy", busy, 1);
         chk("run_ready", cmd_ready, 0);
         chk("run_done", done, 0);
         chk("run_hold", result, last_result);
         scramble_cmd();
         @(negedge clk);
      end
      chk("done_pulse", done, 1);
      chk("done_result", result, exp_res);
      chk("done_busy", busy, 0);
      chk("done_ready", cmd_ready, 1);
      chk("done_sel", usr_sel, 0);
      last_result = exp_res;
      cmd_valid = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      cmd_valid = 1'b0;
      cmd_data = 4'b0000;
      cmd_dir = 1'b0;
      cmd_count = 3'b000;
      abort = 1'b0;
      abort_accept = 1'b0;
      last_result = 4'b0000;
      #12;
      chk("rst_sel", usr_sel, 0);
      chk("rst_data", usr_data, 0);
      chk("rst_result", result, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      idle(2);

      run_cmd(4'b1010, 1'b1, 3'd2);
      chk("left_const", result, 4'b1000);
      @(negedge clk);
      idle(1);
      run_cmd(4'b1010, 1'b0, 3'd1);
      chk("right_const", result, 4'b0101);
      @(negedge clk);
      idle(1);
      run_cmd(4'b0110, 1'b0, 3'd0);
      chk("zero_const", result, 4'b0110);
      @(negedge clk);
      idle(1);

      // Back-to-back: second command presented in the done cycle.
      run_cmd(4'b1010, 1'b1, 3'd1);
      chk("b2b_first", result, 4'b0100);
      run_cmd(4'b0011, 1'b0, 3'd2);
      chk("b2b_second", result, 4'b0000);
      @(negedge clk);
      idle(1);

      // Reset during SHIFT, after a nonzero result.
      run_cmd(4'b0111, 1'b0, 3'd0);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data = 4'b1111;
      cmd_dir = 1'b1;
      cmd_count = 3'd5;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_sel", usr_sel, 2'b10);
      resetn = 1'b0;
      #1;
      chk("mid_rst_sel", usr_sel, 0);
      chk("mid_rst_data", usr_data, 0);
      chk("mid_rst_result", result, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      @(negedge clk);
      resetn = 1'b1;
      last_result = 4'b0000;
      @(negedge clk);
      idle(8);
      run_cmd(4'b1001, 1'b1, 3'd1);
      @(negedge clk);
      idle(1);

`ifdef SHIFT_SEQUENCER_ABORT_EN
      run_cmd(4'b1010, 1'b0, 3'd1);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_data = 4'b1111;
      cmd_dir = 1'b1;
      cmd_count = 3'd3;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_pre_sel", usr_sel, 2'b10);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_sel", usr_sel, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_result", result, 4'b0101);
      idle(4);
      abort_accept = 1'b1;
      run_cmd(4'b0011, 1'b1, 3'd2);
      abort_accept = 1'b0;
      @(negedge clk);
      idle(1);
`endif

      // Random commands with random gaps (including back-to-back).
      for (int i = 0; i < 30; i++) begin
         run_cmd(4'($urandom), 1'($urandom), 3'($urandom));
         if ($urandom_range(0, 2) != 0) begin
            @(negedge clk);
            idle($urandom_range(0, 2));
         end
      end
      @(negedge clk);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
